mlp_layer_seq: RTL and testbench
================================

Name: mlp_layer_seq

Overview:
- Self-sequenced fully-connected layer for the MLP datapath.
- Accepts N_INPUTS activations through a valid/ready stream and multiplies each by per-neuron weights from internal synchronous-read weight memories.
- Adds a per-neuron bias, rescales the fixed-point result, applies a run-selectable activation (ReLU or identity) with signed saturation, and presents all outputs with a one-cycle out_valid pulse.
- Layers chain directly: outputs_flat/out_valid of one instance feed the next instance's controller.

Parameters:
- N_INPUTS, 4, inputs per neuron (≥2).
- N_NEURONS, 8, neurons in the layer (≥1).
- IN_WIDTH, 16, signed input width.
- WGT_WIDTH, 16, signed weight and bias width.
- MAC_WIDTH, 40, signed accumulator width.
- OUT_WIDTH, 16, signed output width.
- FRAC_BITS, 8, fractional bits of inputs, weights, bias and outputs.

Ports:
- clk, in, 1, clock; all logic on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- wr_en, in, 1, weight write strobe.
- wr_weight, in, WGT_WIDTH, weight value.
- wr_row, in, clog2(N_NEURONS), neuron index.
- wr_col, in, clog2(N_INPUTS), input index.
- bias_wr_en, in, 1, bias write strobe.
- bias_row, in, clog2(N_NEURONS), neuron index.
- bias_value, in, WGT_WIDTH, bias value.
- start, in, 1, begin a run (pulse).
- act_relu, in, 1, 1 = ReLU, 0 = identity; sampled on start.
- in_data, in, IN_WIDTH, signed input activation.
- in_valid, in, 1, in_data valid.
- in_ready, out, 1, layer accepts input.
- busy, out, 1, run in progress.
- out_valid, out, 1, one-cycle pulse: outputs_flat updated.
- outputs_flat, out, N_NEURONS*OUT_WIDTH, neuron n at [n*OUT_WIDTH +: OUT_WIDTH].

Behaviour:
- Reset values:
  - state IDLE; busy, in_ready, out_valid = 0.
  - outputs_flat, accumulators, input counter = 0.
  - bias registers = 0.
  - weight memories are not reset.
- FSM: IDLE → LOAD → FLUSH → ACT → IDLE.
- IDLE:
  - in_ready = 0, busy = 0.
  - Weight and bias writes are honoured.
  - On start: latch act_relu, load acc[n] = sign_ext(bias[n]) << FRAC_BITS, clear the counter, go to LOAD.
- LOAD:
  - busy = 1, in_ready = 1.
  - Each accept (in_valid && in_ready) registers in_data and issues weight read address = counter; the counter then increments.
  - The registered input and read weight are MAC'd on the following edge: acc[n] += in × w[n][idx], full-precision product sign-extended to MAC_WIDTH.
  - Bubbles (in_valid = 0) perform no MAC.
  - The accept with counter = N_INPUTS−1 moves to FLUSH.
- FLUSH:
  - in_ready = 0.
  - Final MAC completes; go to ACT.
- ACT:
  - in_ready = 0.
  - Per neuron: r = acc >>> FRAC_BITS (arithmetic, truncate toward −∞).
  - If ReLU and r < 0, r = 0.
  - Saturate to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
  - Register into outputs_flat and pulse out_valid on the same edge; return to IDLE.
- Latency: out_valid is high in the second cycle after the edge accepting the last input (edges E0 accept, E1 FLUSH, E2 ACT → outputs).
- outputs_flat holds its value until the next ACT.
- Accumulator overflow wraps modulo 2^MAC_WIDTH; no internal saturation.
- Weight memory: one per neuron, depth N_INPUTS, synchronous read.
  - Write address = wr_col when wr_en && busy = 0.
  - Read address = counter during LOAD.
- Boundary conditions:
  - start while busy: ignored.
  - start and in_valid in the same IDLE cycle: start taken; no input accepted.
  - wr_en or bias_wr_en while busy: ignored (write dropped, no corruption).
  - wr_en and bias_wr_en together in IDLE: both performed.
  - wr_row ≥ N_NEURONS or wr_col ≥ N_INPUTS: write dropped.
  - rst_n low mid-run: immediate return to IDLE with reset values; no out_valid for the aborted run. Weights are retained; biases are cleared.
  - Back-to-back runs: start may be asserted in the cycle out_valid is high (state is already IDLE).

Test Plan:
Common setup: defaults, N_INPUTS = 4, N_NEURONS = 2, FRAC_BITS = 8.
- Basic run:
  - Stimulus: w0 = 0x0100 ×4; w1 = 0xFF00 ×4; bias 0; inputs 0x0100, 0x0200, 0x0300, 0x0400 back-to-back.
  - act_relu = 0 → out0 = 0x0A00, out1 = 0xF600; out_valid 2 cycles after the 4th accept.
  - act_relu = 1 → out1 = 0x0000.
- Bias: same as the basic run with bias0 = 0x0080 → out0 = 0x0A80.
- Saturation: all weights and inputs 0x7FFF.
  - Identity mode, w1 = 0x8001 → out0 = 0x7FFF, out1 = 0x8000.
  - ReLU mode → out1 = 0x0000.
- Backpressure: basic-run inputs with in_valid deasserted for 3 cycles between each → identical outputs; in_ready stays high throughout LOAD; exactly one out_valid pulse.
- Reset and illegal operations:
  - rst_n pulse after 2 accepts → busy = 0, outputs_flat = 0, no out_valid.
  - A fresh run then matches the basic run.
  - wr_en with new weights during LOAD is ignored, and a subsequent run is unchanged.
- Back-to-back: start asserted in the out_valid cycle → second run accepted; in_ready rises on the next cycle; results are correct.

Source files
------------

// File: rtl/mlp_layer_seq.sv
// Self-sequenced fully-connected layer: streams N_INPUTS activations, MACs them against
// per-neuron weight memories, then adds bias, rescales, activates and saturates.
module mlp_layer_seq #(
   parameter int unsigned N_INPUTS  = 4,
   parameter int unsigned N_NEURONS = 8,
   parameter int unsigned IN_WIDTH  = 16,
   parameter int unsigned WGT_WIDTH = 16,
   parameter int unsigned MAC_WIDTH = 40,
   parameter int unsigned OUT_WIDTH = 16,
   parameter int unsigned FRAC_BITS = 8,
   localparam int unsigned RW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
   localparam int unsigned CW = $clog2(N_INPUTS)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           wr_en,
   input  logic [WGT_WIDTH-1:0]           wr_weight,
   input  logic [RW-1:0]                  wr_row,
   input  logic [CW-1:0]                  wr_col,
   input  logic                           bias_wr_en,
   input  logic [RW-1:0]                  bias_row,
   input  logic [WGT_WIDTH-1:0]           bias_value,
   input  logic                           start,
   input  logic                           act_relu,
   input  logic [IN_WIDTH-1:0]            in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic                           busy,
   output logic                           out_valid,
   output logic [N_NEURONS*OUT_WIDTH-1:0] outputs_flat
);

   localparam int unsigned PW = IN_WIDTH + WGT_WIDTH;

   typedef enum logic [1:0] {StIdle, StLoad, StFlush, StAct} state_e;

   state_e                        state_q, state_d;
   logic                          relu_q;
   logic [CW-1:0]                 cnt_q;
   logic [IN_WIDTH-1:0]           in_q;
   logic                          mac_en_q;
   logic                          out_valid_q;
   logic [N_NEURONS*OUT_WIDTH-1:0] out_q;
   logic [N_NEURONS*OUT_WIDTH-1:0] act_out;

   logic [WGT_WIDTH-1:0]          wmem    [N_NEURONS][N_INPUTS];
   logic [WGT_WIDTH-1:0]          w_rd_q  [N_NEURONS];
   logic [WGT_WIDTH-1:0]          bias_q  [N_NEURONS];
   logic signed [MAC_WIDTH-1:0]   acc_q   [N_NEURONS];
   logic signed [PW-1:0]          prod    [N_NEURONS];
   logic signed [MAC_WIDTH-1:0]   shr     [N_NEURONS];

   logic accept, last_in, idle;

   assign idle     = (state_q == StIdle);
   assign in_ready = (state_q == StLoad);
   assign busy     = !idle;
   assign accept   = in_valid && in_ready;
   assign last_in  = (32'(cnt_q) == N_INPUTS - 1);

   assign out_valid    = out_valid_q;
   assign outputs_flat = out_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StLoad;
         StLoad:  if (accept && last_in) state_d = StFlush;
         StFlush: state_d = StAct;
         StAct:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Weight memories carry no reset so they survive an aborted run.
   always_ff @(posedge clk) begin
      for (int n = 0; n < N_NEURONS; n++) begin
         for (int i = 0; i < N_INPUTS; i++) begin
            if (wr_en && idle && wr_row == RW'(n) && wr_col == CW'(i)) begin
               wmem[n][i] <= wr_weight;
            end
         end
         if (accept) w_rd_q[n] <= wmem[n][cnt_q];
      end
   end

   always_comb begin
      for (int n = 0; n < N_NEURONS; n++) begin
         prod[n] = $signed(in_q) * $signed(w_rd_q[n]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         relu_q   <= 1'b0;
         cnt_q    <= '0;
         in_q     <= '0;
         mac_en_q <= 1'b0;
         for (int n = 0; n < N_NEURONS; n++) begin
            acc_q[n]  <= '0;
            bias_q[n] <= '0;
         end
      end else begin
         mac_en_q <= accept;
         if (accept) begin
            in_q  <= in_data;
            cnt_q <= cnt_q + CW'(1);
         end
         for (int n = 0; n < N_NEURONS; n++) begin
            if (idle && start) begin
               acc_q[n] <= {{(MAC_WIDTH-WGT_WIDTH-FRAC_BITS){bias_q[n][WGT_WIDTH-1]}},
                            bias_q[n], {FRAC_BITS{1'b0}}};
            end else if (mac_en_q) begin
               acc_q[n] <= acc_q[n] + {{(MAC_WIDTH-PW){prod[n][PW-1]}}, prod[n]};
            end
            if (bias_wr_en && idle && bias_row == RW'(n)) bias_q[n] <= bias_value;
         end
         if (idle && start) begin
            relu_q <= act_relu;
            cnt_q  <= '0;
         end
      end
   end

   // Rescale, optional ReLU, then clamp when the upper bits are not a pure sign extension.
   always_comb begin
      act_out = '0;
      for (int n = 0; n < N_NEURONS; n++) begin
         shr[n] = acc_q[n] >>> FRAC_BITS;
         if (relu_q && shr[n][MAC_WIDTH-1]) shr[n] = '0;
         if ((&shr[n][MAC_WIDTH-1:OUT_WIDTH-1]) || !(|shr[n][MAC_WIDTH-1:OUT_WIDTH-1])) begin
            act_out[n*OUT_WIDTH +: OUT_WIDTH] = shr[n][OUT_WIDTH-1:0];
         end else begin
            act_out[n*OUT_WIDTH +: OUT_WIDTH] = {shr[n][MAC_WIDTH-1],
                                                 {(OUT_WIDTH-1){!shr[n][MAC_WIDTH-1]}}};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= (state_q == StAct);
         if (state_q == StAct) out_q <= act_out;
      end
   end

endmodule

// File: tb/tb_mlp_layer_seq.sv
// Directed and randomized bench for mlp_layer_seq against an arithmetic reference model.
module tb_mlp_layer_seq;

   localparam int NI = 4;
   localparam int NN = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en, bias_wr_en, start, act_relu, in_valid;
   logic [15:0] wr_weight, bias_value, in_data;
   logic [0:0]  wr_row, bias_row;
   logic [1:0]  wr_col;
   logic        in_ready, busy, out_valid;
   logic [31:0] outputs_flat;

   int errors = 0;
   int checks = 0;

   shortint cur_w  [NN][NI];
   shortint cur_b  [NN];
   shortint cur_in [NI];

   mlp_layer_seq #(
      .N_INPUTS (NI),
      .N_NEURONS(NN)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_weight   (wr_weight),
      .wr_row      (wr_row),
      .wr_col      (wr_col),
      .bias_wr_en  (bias_wr_en),
      .bias_row    (bias_row),
      .bias_value  (bias_value),
      .start       (start),
      .act_relu    (act_relu),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .busy        (busy),
      .out_valid   (out_valid),
      .outputs_flat(outputs_flat)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Q8.8 dot product plus bias, 40-bit wrap, floor shift, activation, clamp.
   function automatic logic [15:0] model(input int n, input bit relu);
      longint s, r;
      s = longint'(cur_b[n]) * 256;
      for (int i = 0; i < NI; i++) s += longint'(cur_in[i]) * longint'(cur_w[n][i]);
      s = (s <<< 24) >>> 24;
      r = s >>> 8;
      if (relu && r < 0) r = 0;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return r[15:0];
   endfunction

   task automatic wr(input int row, input int col, input shortint w, input bit ben,
                     input shortint b);
      @(negedge clk);
      wr_en = 1'b1; wr_row = 1'(row); wr_col = 2'(col); wr_weight = w;
      bias_wr_en = ben; bias_row = 1'(row); bias_value = b;
      @(negedge clk);
      wr_en = 1'b0; bias_wr_en = 1'b0;
   endtask

   task automatic load_all();
      for (int n = 0; n < NN; n++)
         for (int i = 0; i < NI; i++) wr(n, i, cur_w[n][i], i == 0, cur_b[n]);
   endtask

   // Assumes the caller is at a negedge with the layer idle (or in its out_valid cycle).
   task automatic begin_run(input bit relu, input bit junk);
      start = 1'b1; act_relu = relu;
      if (junk) begin in_valid = 1'b1; in_data = 16'h5A5A; end
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0;
      chk("run_ready", {63'd0, in_ready}, 64'd1);
      chk("run_busy", {63'd0, busy}, 64'd1);
   endtask

   task automatic feed(input int gap);
      for (int i = 0; i < NI; i++) begin
         for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0; in_data = 16'hDEAD;
            @(negedge clk);
            chk("gap_ready", {63'd0, in_ready}, 64'd1);
         end
         chk("load_nopulse", {63'd0, out_valid}, 64'd0);
         in_valid = 1'b1; in_data = cur_in[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic finish_run(input bit relu, input bit drop_chk);
      int cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!out_valid && cyc < 10);
      chk("latency", 64'(cyc), 64'd2);
      for (int n = 0; n < NN; n++) chk("out", {48'd0, outputs_flat[n*16 +: 16]}, {48'd0, model(n, relu)});
      chk("idle_busy", {63'd0, busy}, 64'd0);
      if (drop_chk) begin
         @(negedge clk);
         chk("pulse_once", {63'd0, out_valid}, 64'd0);
      end
   endtask

   task automatic set_basic(input shortint b0);
      for (int i = 0; i < NI; i++) begin
         cur_w[0][i] = 16'sh0100;
         cur_w[1][i] = 16'shFF00;
         cur_in[i]   = shortint'((i + 1) * 256);
      end
      cur_b[0] = b0; cur_b[1] = 0;
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 0; bias_wr_en = 0; start = 0; act_relu = 0; in_valid = 0;
      wr_weight = 0; bias_value = 0; in_data = 0; wr_row = 0; bias_row = 0; wr_col = 0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out", {32'd0, outputs_flat}, 64'd0);
      rst_n = 1'b1;

      // Basic run, identity then ReLU
      set_basic(0); load_all();
      @(negedge clk); begin_run(0, 0); feed(0); finish_run(0, 1);
      chk("basic_lit", {32'd0, outputs_flat}, 64'h0000_0000_F600_0A00);
      begin_run(1, 0); feed(0); finish_run(1, 1);
      chk("relu_lit", {32'd0, outputs_flat}, 64'h0000_0000_0000_0A00);

      // Bias, start with in_valid in the same idle cycle
      set_basic(16'sh0080); load_all();
      @(negedge clk); begin_run(0, 1); feed(0); finish_run(0, 1);
      chk("bias_lit", {32'd0, outputs_flat}, 64'h0000_0000_F600_0A80);

      // Saturation
      for (int i = 0; i < NI; i++) begin
         cur_w[0][i] = 16'sh7FFF; cur_w[1][i] = 16'sh8001; cur_in[i] = 16'sh7FFF;
      end
      cur_b[0] = 0; cur_b[1] = 0; load_all();
      @(negedge clk); begin_run(0, 0); feed(0); finish_run(0, 1);
      chk("sat_lit", {32'd0, outputs_flat}, 64'h0000_0000_8000_7FFF);
      begin_run(1, 0); feed(0); finish_run(1, 1);
      chk("sat_relu_lit", {32'd0, outputs_flat}, 64'h0000_0000_0000_7FFF);

      // Backpressure
      set_basic(0); load_all();
      @(negedge clk); begin_run(0, 0); feed(3); finish_run(0, 1);

      // Reset mid-run: biases cleared, weights kept
      set_basic(16'sh0080); load_all();
      @(negedge clk); begin_run(0, 0);
      for (int i = 0; i < 2; i++) begin in_valid = 1'b1; in_data = cur_in[i]; @(negedge clk); end
      in_valid = 1'b0; rst_n = 1'b0;
      #2;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_out", {32'd0, outputs_flat}, 64'd0);
      chk("abort_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk); rst_n = 1'b1; cur_b[0] = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("abort_nopulse", {63'd0, out_valid}, 64'd0);
      end
      begin_run(0, 0); feed(0); finish_run(0, 1);
      chk("fresh_lit", {32'd0, outputs_flat}, 64'h0000_0000_F600_0A00);

      // Writes and start while busy are dropped
      begin_run(0, 0);
      wr_en = 1'b1; wr_row = 0; wr_col = 1; wr_weight = 16'h4000;
      bias_wr_en = 1'b1; bias_row = 1; bias_value = 16'h7000; start = 1'b1;
      feed(0);
      start = 1'b0; wr_en = 1'b0; bias_wr_en = 1'b0;
      finish_run(0, 1);
      begin_run(0, 0); feed(0); finish_run(0, 1);

      // Back-to-back: second start in the out_valid cycle
      begin_run(0, 0); feed(0); finish_run(0, 0);
      for (int i = 0; i < NI; i++) cur_in[i] = shortint'(-(i + 2) * 128);
      begin_run(1, 0); feed(1); finish_run(1, 1);

      // Randomized runs
      for (int t = 0; t < 8; t++) begin
         bit r;
         for (int n = 0; n < NN; n++) begin
            for (int i = 0; i < NI; i++) cur_w[n][i] = shortint'($urandom);
            cur_b[n] = shortint'($urandom);
         end
         for (int i = 0; i < NI; i++) cur_in[i] = shortint'($urandom);
         r = 1'($urandom_range(0, 1));
         load_all();
         @(negedge clk); begin_run(r, 1'($urandom_range(0, 1)));
         feed(int'($urandom_range(0, 2))); finish_run(r, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
